hs32_wb_bridge: RTL and testbench
=================================

# hs32_wb_bridge

Wishbone classic slave that bridges the management-SoC Wishbone port of the user project into the HS32 core's valid/ready memory request bus. It sits directly upstream of the core inside the user project wrapper. It also exposes a small control register that holds the core in reset or halt and reports bus timeouts. A watchdog counter guarantees that every Wishbone cycle is acknowledged, even when the core side never responds.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, base of the core memory window
- WIN_MASK, 32'hFFF0_0000, upper address bits compared against BASE_ADDR; the remaining bits form the offset
- CTRL_ADDR, 32'h3100_0000, word address of the control register
- TIMEOUT, 255, number of cycles in REQ+WAIT before the cycle is forced to complete (8-bit counter)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone cycle, strobe and write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32  address and write data
- wbs_ack_o  out  1  acknowledge, registered
- wbs_dat_o  out  32  read data, registered
- mem_req_o  out  1  request valid
- mem_rdy_i  in  1  request accepted
- mem_we_o  out  1  write request
- mem_sel_o  out  4  byte selects
- mem_addr_o  out  32  window offset (wbs_adr_i & ~WIN_MASK)
- mem_wdata_o  out  32  write data
- mem_rvalid_i  in  1  read response valid
- mem_rdata_i  in  32  read response data
- core_rst_no  out  1  core reset, active-low (equals CTRL.run)
- core_halt_o  out  1  core halt (equals CTRL.halt)
- err_o  out  1  sticky timeout flag (equals CTRL.err)

## Operation
- Reset values: all outputs 0. The FSM is in IDLE and CTRL = 0, so the core is held in reset.
- A transaction is cyc&stb sampled in IDLE. Decode priority: CTRL_ADDR, then the window ((adr & WIN_MASK) == BASE_ADDR), then unmapped.
- Unmapped: go to ACK. Read data = 0, no side effects.
- CTRL (bit0 run, bit1 halt, bit2 err):
  - A write with sel[0]=1 updates run and halt. Writing 1 to bit2 clears err.
  - A read returns {29'b0, err, halt, run}.
  - Then go to ACK.
- Window: latch we, sel, offset and data onto the mem_* outputs, assert mem_req_o, and go to REQ.
- REQ: hold all mem_* outputs stable until mem_rdy_i. On the handshake, drop mem_req_o; a write goes to ACK, a read goes to WAIT.
- WAIT: on mem_rvalid_i, capture mem_rdata_i into wbs_dat_o and go to ACK.
- ACK: wbs_ack_o is high for exactly one cycle, then return to IDLE. wbs_dat_o is held until the next ACK.
- Timeout: the counter clears on entry to REQ and counts every cycle in REQ/WAIT.
  - On reaching TIMEOUT, drop mem_req_o, set err, and go to ACK.
  - A timed-out read returns 32'hDEAD_BEEF; a timed-out write is acknowledged normally.
- Abort (cyc drops):
  - In REQ: drop mem_req_o and go to IDLE.
  - In WAIT: go to DRAIN.
  - DRAIN consumes one mem_rvalid_i (or times out), with no ack and no data update, then goes to IDLE. This guarantees no stale response reaches a later cycle.
- mem_rvalid_i is ignored in every state other than WAIT and DRAIN.
- CTRL and unmapped accesses are served regardless of the run and halt bits.

## Timing
- Edge 0 samples the request. CTRL and unmapped accesses have wbs_ack_o high during cycle 1 (one wait state).
- Window write with mem_rdy_i already high: mem_req_o is high in cycle 1, the handshake happens at edge 1, and ack is high in cycle 2.
- Window read: ack is high the cycle after the edge that samples mem_rvalid_i. mem_rvalid_i is never expected in the same cycle as the handshake.
- Timeout: ack is high TIMEOUT+1 cycles after REQ entry.
- Asynchronous reset mid-operation forces IDLE immediately, drops mem_req_o and ack, and clears CTRL.

## Structure
- Package hs32_wb_bridge_pkg holds:
  - the state enum (IDLE, REQ, WAIT, ACK, DRAIN);
  - the CTRL bit indices;
  - the constant TMO_DATA = 32'hDEAD_BEEF.
- One sub-module, hs32_wb_tmo: a clearable 8-bit counter with enable and a `hit` output at TIMEOUT.

## Test plan
- After reset, read CTRL_ADDR: response is 0 and core_rst_no=0. Write 32'h3 with sel=4'h1: core_rst_no=1, core_halt_o=1, ack exactly 1 cycle after strobe.
- Write 32'h1234_5678 to 32'h3000_0010 with mem_rdy_i tied high: mem_addr_o=32'h10, mem_wdata_o=32'h1234_5678, mem_we_o=1, ack in cycle 2.
- Read 32'h3000_0020 with mem_rdy_i delayed 3 cycles and rvalid 2 cycles after the handshake returning 32'hCAFE_F00D: mem_* stable while waiting, wbs_dat_o=32'hCAFE_F00D, single ack.
- Read with mem_rdy_i stuck low: after 255 cycles wbs_dat_o=32'hDEAD_BEEF, err_o=1. Write 32'h4 to CTRL: err_o=0.
- Read 32'h3000_0000, drop cyc in WAIT, issue a new read, then rvalid(32'h1111_1111), then rvalid(32'h2222_2222): first response discarded, second read returns 32'h2222_2222.
- Read unmapped 32'h2000_0000: returns 0 with ack in cycle 1, no mem_req_o. Assert reset during REQ: mem_req_o falls immediately.

Source files
------------

// File: rtl/hs32_wb_bridge_pkg.sv
// Shared types and constants for the HS32 Wishbone bridge.
package hs32_wb_bridge_pkg;

    // Bridge transaction states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Control register bit positions
    localparam int CTRL_RUN  = 0;
    localparam int CTRL_HALT = 1;
    localparam int CTRL_ERR  = 2;

    // Read data returned when a core-side read times out
    localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/hs32_wb_tmo.sv
// Clearable saturating 8-bit watchdog counter; hit_o flags the limit.
module hs32_wb_tmo #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/hs32_wb_bridge.sv
// Wishbone classic slave bridging the management SoC into the HS32 core
// valid/ready memory bus, plus a run/halt/err control register. A watchdog
// guarantees every Wishbone cycle is acknowledged.
module hs32_wb_bridge
    import hs32_wb_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] WIN_MASK  = 32'hFFF0_0000,
    parameter logic [31:0] CTRL_ADDR = 32'h3100_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        mem_req_o,
    input  logic        mem_rdy_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        core_rst_no,
    output logic        core_halt_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_sel_q, mem_sel_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [2:0]  ctrl_q, ctrl_d;

    logic        tmo_hit;
    logic        tmo_clr;
    logic        tmo_en;
    logic        wb_req;

    assign wb_req = wbs_cyc_i && wbs_stb_i;

    // Watchdog restarts on entry to REQ or DRAIN so each phase gets a full budget
    assign tmo_clr = (state_d != state_q) && ((state_d == ST_REQ) || (state_d == ST_DRAIN));
    assign tmo_en  = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    hs32_wb_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .clr_i  (tmo_clr),
        .en_i   (tmo_en),
        .hit_o  (tmo_hit)
    );

    // Next-state, bus-side latches, control register and response data
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dat_d       = dat_q;
        ctrl_d      = ctrl_q;

        case (state_q)
            ST_IDLE: begin
                if (wb_req) begin
                    if (wbs_adr_i == CTRL_ADDR) begin
                        if (wbs_we_i) begin
                            if (wbs_sel_i[0]) begin
                                ctrl_d[CTRL_RUN]  = wbs_dat_i[CTRL_RUN];
                                ctrl_d[CTRL_HALT] = wbs_dat_i[CTRL_HALT];
                                if (wbs_dat_i[CTRL_ERR]) begin
                                    ctrl_d[CTRL_ERR] = 1'b0;
                                end
                            end
                        end else begin
                            dat_d = {29'b0, ctrl_q};
                        end
                        state_d = ST_ACK;
                    end else if ((wbs_adr_i & WIN_MASK) == BASE_ADDR) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = wbs_we_i;
                        mem_sel_d   = wbs_sel_i;
                        mem_addr_d  = wbs_adr_i & ~WIN_MASK;
                        mem_wdata_d = wbs_dat_i;
                        state_d     = ST_REQ;
                    end else begin
                        dat_d   = 32'h0;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_REQ: begin
                if (mem_rdy_i) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = wbs_cyc_i ? ST_ACK : ST_IDLE;
                    end else begin
                        // A read already accepted must have its response drained
                        state_d = wbs_cyc_i ? ST_WAIT : ST_DRAIN;
                    end
                end else if (!wbs_cyc_i) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (tmo_hit) begin
                    mem_req_d        = 1'b0;
                    ctrl_d[CTRL_ERR] = 1'b1;
                    if (!mem_we_q) begin
                        dat_d = TMO_DATA;
                    end
                    state_d = ST_ACK;
                end
            end
            ST_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = mem_rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid_i) begin
                    dat_d   = mem_rdata_i;
                    state_d = ST_ACK;
                end else if (tmo_hit) begin
                    ctrl_d[CTRL_ERR] = 1'b1;
                    dat_d            = TMO_DATA;
                    state_d          = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (mem_rvalid_i || tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d = (state_d == ST_ACK);
    end

    // State and output registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            ack_q       <= 1'b0;
            dat_q       <= 32'h0;
            ctrl_q      <= 3'b000;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_sel_o   = mem_sel_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign core_rst_no = ctrl_q[CTRL_RUN];
    assign core_halt_o = ctrl_q[CTRL_HALT];
    assign err_o       = ctrl_q[CTRL_ERR];

endmodule

// File: tb/tb_hs32_wb_bridge.sv
// Self-checking bench for hs32_wb_bridge: a vector table of single-shot
// transactions plus hand-written multi-cycle sequences.
module tb_hs32_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        mem_req, mem_rdy, mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        core_rst_n, core_halt, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hs32_wb_bridge dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .mem_req_o    (mem_req),
        .mem_rdy_i    (mem_rdy),
        .mem_we_o     (mem_we),
        .mem_sel_o    (mem_sel),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .core_rst_no  (core_rst_n),
        .core_halt_o  (core_halt),
        .err_o        (err)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          lat;
        logic [31:0] rd;
        int          reqs;
        logic [31:0] maddr;
        logic        run;
        logic        halt;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        int          acks;
        int          reqs;
        logic        stable;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        mwe;
        logic [3:0]  msel;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One Wishbone transaction; request is sampled at edge 0, cycle n follows edge n-1.
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input int rdy_delay, input int rv_delay,
                           input logic [31:0] rv_data, output res_t r);
        int  hs;
        bit  done;
        r  = '{lat: -1, rd: 32'h0, acks: 0, reqs: 0, stable: 1'b1,
               maddr: 32'h0, mwdata: 32'h0, mwe: 1'b0, msel: 4'h0};
        hs   = -1;
        done = 1'b0;
        @(negedge clk);
        adr = a; we = w; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
        mem_rdy = 1'b0; mem_rvalid = 1'b0;
        for (int n = 1; n < 400 && !done; n++) begin
            @(negedge clk);
            mem_rdy    = 1'b0;
            mem_rvalid = 1'b0;
            if (ack) begin
                r.acks++;
                if (r.lat < 0) begin
                    r.lat = n;
                    r.rd  = rdat;
                end
            end
            if (mem_req) begin
                r.reqs++;
                if (r.reqs == 1) begin
                    r.maddr = mem_addr; r.mwdata = mem_wdata; r.mwe = mem_we; r.msel = mem_sel;
                end else if (mem_addr !== r.maddr || mem_wdata !== r.mwdata ||
                             mem_we !== r.mwe || mem_sel !== r.msel) begin
                    r.stable = 1'b0;
                end
                if (r.reqs == rdy_delay + 1) begin
                    mem_rdy = 1'b1;
                    hs      = n;
                end
            end
            if (hs >= 0 && !w && n == hs + rv_delay) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rv_data;
            end
            if (r.lat > 0) begin
                cyc = 1'b0;
                stb = 1'b0;
                if (n == r.lat + 2) done = 1'b1;
            end
        end
        cyc = 1'b0; stb = 1'b0; mem_rdy = 1'b0; mem_rvalid = 1'b0;
        $display("txn adr=%h we=%0d lat=%0d rd=%h reqs=%0d acks=%0d", a, w, r.lat, r.rd, r.reqs, r.acks);
    endtask

    vec_t vecs[13];
    res_t r;

    initial begin
        int   lat, acks;
        logic stale;
        logic [31:0] rd;

        vecs[0]  = '{32'h3100_0000, 1'b0, 4'hF, 32'h0,         1, 32'h0, 0, 32'h0,         1'b0, 1'b0};
        vecs[1]  = '{32'h3100_0000, 1'b1, 4'h1, 32'h3,         1, 32'h0, 0, 32'h0,         1'b1, 1'b1};
        vecs[2]  = '{32'h3100_0000, 1'b0, 4'hF, 32'h0,         1, 32'h3, 0, 32'h0,         1'b1, 1'b1};
        vecs[3]  = '{32'h3100_0000, 1'b1, 4'hE, 32'h0,         1, 32'h0, 0, 32'h0,         1'b1, 1'b1};
        vecs[4]  = '{32'h3100_0000, 1'b0, 4'hF, 32'h0,         1, 32'h3, 0, 32'h0,         1'b1, 1'b1};
        vecs[5]  = '{32'h2000_0000, 1'b0, 4'hF, 32'h0,         1, 32'h0, 0, 32'h0,         1'b1, 1'b1};
        vecs[6]  = '{32'h3000_0010, 1'b1, 4'hF, 32'h1234_5678, 2, 32'h0, 1, 32'h0000_0010, 1'b1, 1'b1};
        vecs[7]  = '{32'h300F_FFFC, 1'b1, 4'h3, 32'h0000_A5A5, 2, 32'h0, 1, 32'h000F_FFFC, 1'b1, 1'b1};
        vecs[8]  = '{32'h3100_0004, 1'b1, 4'hF, 32'hFFFF_FFFF, 1, 32'h0, 0, 32'h0,         1'b1, 1'b1};
        vecs[9]  = '{32'h3100_0000, 1'b0, 4'hF, 32'h0,         1, 32'h3, 0, 32'h0,         1'b1, 1'b1};
        vecs[10] = '{32'h3100_0000, 1'b1, 4'h1, 32'h1,         1, 32'h0, 0, 32'h0,         1'b1, 1'b0};
        vecs[11] = '{32'h3100_0000, 1'b0, 4'hF, 32'h0,         1, 32'h1, 0, 32'h0,         1'b1, 1'b0};
        vecs[12] = '{32'h3010_0000, 1'b0, 4'hF, 32'h0,         1, 32'h0, 0, 32'h0,         1'b1, 1'b0};

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        mem_rdy = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst ack", {31'b0, ack}, 32'h0);
        chk("rst dat", rdat, 32'h0);
        chk("rst mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst mem_sel", {28'b0, mem_sel}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst core_rst_n", {31'b0, core_rst_n}, 32'h0);
        chk("rst halt", {31'b0, core_halt}, 32'h0);
        chk("rst err", {31'b0, err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single transactions with the core side accepting immediately
        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].wdat, 0, 1, 32'h0, r);
            chk($sformatf("v%0d lat", i), r.lat, vecs[i].lat);
            chk($sformatf("v%0d acks", i), r.acks, 1);
            chk($sformatf("v%0d reqs", i), r.reqs, vecs[i].reqs);
            if (!vecs[i].we) chk($sformatf("v%0d rdata", i), r.rd, vecs[i].rd);
            if (vecs[i].reqs == 1) begin
                chk($sformatf("v%0d mem_addr", i), r.maddr, vecs[i].maddr);
                chk($sformatf("v%0d mem_wdata", i), r.mwdata, vecs[i].wdat);
                chk($sformatf("v%0d mem_we", i), {31'b0, r.mwe}, {31'b0, vecs[i].we});
                chk($sformatf("v%0d mem_sel", i), {28'b0, r.msel}, {28'b0, vecs[i].sel});
            end
            chk($sformatf("v%0d core_rst_n", i), {31'b0, core_rst_n}, {31'b0, vecs[i].run});
            chk($sformatf("v%0d halt", i), {31'b0, core_halt}, {31'b0, vecs[i].halt});
        end

        // Read with ready delayed 3 cycles and response 2 cycles after handshake
        run_txn(32'h3000_0020, 1'b0, 4'hF, 32'h0, 3, 2, 32'hCAFE_F00D, r);
        chk("slow rd lat", r.lat, 7);
        chk("slow rd data", r.rd, 32'hCAFE_F00D);
        chk("slow rd acks", r.acks, 1);
        chk("slow rd reqs", r.reqs, 4);
        chk("slow rd stable", {31'b0, r.stable}, 32'h1);
        chk("slow rd addr", r.maddr, 32'h0000_0020);

        // Read with ready stuck low: watchdog completes it
        run_txn(32'h3000_0040, 1'b0, 4'hF, 32'h0, 100000, 1, 32'h0, r);
        chk("tmo lat", r.lat, 257);
        chk("tmo reqs", r.reqs, 256);
        chk("tmo data", r.rd, 32'hDEAD_BEEF);
        chk("tmo acks", r.acks, 1);
        chk("tmo err", {31'b0, err}, 32'h1);
        run_txn(32'h3100_0000, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0, r);
        chk("tmo ctrl rd", r.rd, 32'h5);
        run_txn(32'h3100_0000, 1'b1, 4'h1, 32'h4, 0, 1, 32'h0, r);
        chk("err clr", {31'b0, err}, 32'h0);
        chk("err clr run", {31'b0, core_rst_n}, 32'h0);
        run_txn(32'h3100_0000, 1'b1, 4'h1, 32'h1, 0, 1, 32'h0, r);

        // Abort a read in WAIT; its late response must not reach the next read
        lat = -1; acks = 0; stale = 1'b0; rd = 32'h0;
        @(negedge clk);
        adr = 32'h3000_0000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1; mem_rdy = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (ack) begin
                acks++;
                if (lat < 0) begin lat = n; rd = rdat; end
            end
            if (rdat === 32'h1111_1111) stale = 1'b1;
            case (n)
                2: begin cyc = 1'b0; stb = 1'b0; end
                3: begin cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0004;
                         mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; end
                6: begin mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222; end
                default: ;
            endcase
            if (lat > 0) begin cyc = 1'b0; stb = 1'b0; mem_rdy = 1'b0; end
        end
        $display("abort seq lat=%0d rd=%h acks=%0d", lat, rd, acks);
        chk("abort lat", lat, 7);
        chk("abort data", rd, 32'h2222_2222);
        chk("abort acks", acks, 1);
        chk("abort stale", {31'b0, stale}, 32'h0);

        // Asynchronous reset while a request is outstanding
        @(negedge clk);
        adr = 32'h3000_0008; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1; mem_rdy = 1'b0;
        @(negedge clk);
        chk("pre-rst mem_req", {31'b0, mem_req}, 32'h1);
        chk("pre-rst run", {31'b0, core_rst_n}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mem_req=%0d ack=%0d core_rst_n=%0d", mem_req, ack, core_rst_n);
        chk("arst mem_req", {31'b0, mem_req}, 32'h0);
        chk("arst ack", {31'b0, ack}, 32'h0);
        chk("arst core_rst_n", {31'b0, core_rst_n}, 32'h0);
        chk("arst mem_addr", mem_addr, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(32'h3100_0000, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0, r);
        chk("post-rst ctrl", r.rd, 32'h0);
        chk("post-rst lat", r.lat, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
